// File: rtl/lambert_shade_stage.sv
// Lambert diffuse shading stage: one shared fixed-point multiplier sequenced by an FSM.
// Optional ambient term is enabled by defining SHADE_AMBIENT_EN.
module lambert_shade_stage #(
   parameter int FW   = 32,
   parameter int FRAC = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            hit,
   input  logic [3*FW-1:0] normal,
   input  logic [3*FW-1:0] light_dir,
   input  logic [23:0]     base_color,
   input  logic [23:0]     bg_color,
   input  logic [FW-1:0]   ambient,
   output logic            ready,
   output logic [23:0]     pixel,
   output logic            busy
);

   localparam int AW = FW + 2;
   localparam int CW = FW + 3;
   localparam logic signed [FW-1:0] ONE = FW'(longint'(1) << FRAC);

   typedef enum logic [3:0] {
      IDLE, DOT_X, DOT_Y, DOT_Z, CLAMP, MUL_R, MUL_G, MUL_B, DONE
   } state_t;

   state_t                 state;
   logic signed [FW-1:0]   nx, ny, nz, lx, ly, lz;
   logic signed [FW-1:0]   inten;
   logic        [23:0]     col_q;
   logic        [7:0]      r_q, g_q;
   logic signed [AW-1:0]   acc;
   logic signed [FW-1:0]   mul_a, mul_b, mres;
   logic signed [2*FW-1:0] prod;
   logic        [FW-1:0]   unused_prod_hi;
   logic signed [CW-1:0]   clamp_in;

   function automatic logic signed [FW-1:0] clamp_unit(input logic signed [CW-1:0] v);
      if (v < 0)
         return '0;
      else if (v > CW'(ONE))
         return ONE;
      else
         return v[FW-1:0];
   endfunction

   function automatic logic [7:0] sat8(input logic signed [FW-1:0] v);
      if (v < 0)
         return 8'h00;
      else if (v > 255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

   // Operand selection for the single shared multiplier
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         DOT_X: begin mul_a = nx; mul_b = lx; end
         DOT_Y: begin mul_a = ny; mul_b = ly; end
         DOT_Z: begin mul_a = nz; mul_b = lz; end
         MUL_R: begin mul_a = {{(FW-8){1'b0}}, col_q[23:16]}; mul_b = inten; end
         MUL_G: begin mul_a = {{(FW-8){1'b0}}, col_q[15:8]};  mul_b = inten; end
         MUL_B: begin mul_a = {{(FW-8){1'b0}}, col_q[7:0]};   mul_b = inten; end
         default: begin mul_a = '0; mul_b = '0; end
      endcase
   end

   assign prod = (2*FW)'(mul_a) * (2*FW)'(mul_b);
   assign {unused_prod_hi, mres} = prod >>> FRAC;

`ifdef SHADE_AMBIENT_EN
   logic signed [FW-1:0] amb_q;
   logic signed [AW-1:0] acc_pos;
   assign acc_pos  = acc[AW-1] ? '0 : acc;
   assign clamp_in = CW'(acc_pos) + CW'(amb_q);
`else
   logic unused_ambient;
   assign unused_ambient = ^ambient;
   assign clamp_in       = CW'(acc);
`endif

   // Operand capture and intermediate channel results; no reset needed
   always_ff @(posedge clock) begin
      if (state == IDLE && start) begin
         nx    <= normal[3*FW-1:2*FW];
         ny    <= normal[2*FW-1:FW];
         nz    <= normal[FW-1:0];
         lx    <= light_dir[3*FW-1:2*FW];
         ly    <= light_dir[2*FW-1:FW];
         lz    <= light_dir[FW-1:0];
         col_q <= base_color;
`ifdef SHADE_AMBIENT_EN
         amb_q <= ambient;
`endif
      end
      if (state == CLAMP) inten <= clamp_unit(clamp_in);
      if (state == MUL_R) r_q   <= sat8(mres);
      if (state == MUL_G) g_q   <= sat8(mres);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         ready <= 1'b0;
         pixel <= 24'h0;
         acc   <= '0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  if (hit) begin
                     state <= DOT_X;
                  end else begin
                     pixel <= bg_color;
                     ready <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DOT_X: begin acc <= acc + AW'(mres); state <= DOT_Y; end
            DOT_Y: begin acc <= acc + AW'(mres); state <= DOT_Z; end
            DOT_Z: begin acc <= acc + AW'(mres); state <= CLAMP; end
            CLAMP: state <= MUL_R;
            MUL_R: state <= MUL_G;
            MUL_G: state <= MUL_B;
            MUL_B: begin
               pixel <= {r_q, g_q, sat8(mres)};
               ready <= 1'b1;
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_lambert_shade_stage.sv
// Bench for lambert_shade_stage: directed cases plus randomized traffic against a cycle-count model.
module tb_lambert_shade_stage;

   logic        clock;
   logic        reset;
   logic        start;
   logic        hit;
   logic [95:0] normal;
   logic [95:0] light_dir;
   logic [23:0] base_color;
   logic [23:0] bg_color;
   logic [31:0] ambient;
   logic        ready;
   logic [23:0] pixel;
   logic        busy;

   int nvec = 0;
   int nerr = 0;

   lambert_shade_stage #(.FW(32), .FRAC(16)) dut (
      .clock(clock), .reset(reset), .start(start), .hit(hit),
      .normal(normal), .light_dir(light_dir),
      .base_color(base_color), .bg_color(bg_color), .ambient(ambient),
      .ready(ready), .pixel(pixel), .busy(busy)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // Shaded colour straight from the arithmetic rules
   function automatic logic [23:0] model_px(input logic [95:0] n, input logic [95:0] l,
                                            input logic [23:0] c, input logic [31:0] amb);
      longint d;
      logic [23:0] px;
      d = 0;
      for (int i = 0; i < 3; i++) begin
         longint a, b;
         a = longint'($signed(n[32*i +: 32]));
         b = longint'($signed(l[32*i +: 32]));
         d = d + ((a * b) >>> 16);
      end
`ifdef SHADE_AMBIENT_EN
      if (d < 0) d = 0;
      d = d + longint'($signed(amb));
`else
      if (amb == 32'hDEAD_BEEF) d = d + 0;
`endif
      if (d < 0) d = 0;
      if (d > 65536) d = 65536;
      px = '0;
      for (int i = 0; i < 3; i++) begin
         longint v;
         v = (longint'(c[8*i +: 8]) * d) >>> 16;
         if (v > 255) v = 255;
         px[8*i +: 8] = v[7:0];
      end
      return px;
   endfunction

   // Expected outputs for the cycle following each rising edge
   int          remain = 0;
   logic [23:0] pend = '0;
   logic [23:0] exp_pixel = '0;
   logic        exp_ready = 1'b0;
   logic        exp_busy = 1'b0;

   always @(posedge clock) begin
      if (!reset) begin
         remain    = 0;
         exp_ready = 1'b0;
         exp_pixel = 24'h0;
      end else if (remain == 0) begin
         exp_ready = 1'b0;
         if (start) begin
            if (hit) begin
               remain = 8;
               pend   = model_px(normal, light_dir, base_color, ambient);
            end else begin
               remain    = 1;
               exp_pixel = bg_color;
               exp_ready = 1'b1;
            end
         end
      end else begin
         remain    = remain - 1;
         exp_ready = (remain == 1);
         if (remain == 1) exp_pixel = pend;
      end
      exp_busy = (remain > 0);
   end

   always @(negedge clock) begin
      nvec++;
      if (ready !== exp_ready) begin
         nerr++;
         $display("FAIL ready t=%0t actual=%b required=%b", $time, ready, exp_ready);
      end
      nvec++;
      if (busy !== exp_busy) begin
         nerr++;
         $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, exp_busy);
      end
      nvec++;
      if (pixel !== exp_pixel) begin
         nerr++;
         $display("FAIL pixel t=%0t actual=%h required=%h", $time, pixel, exp_pixel);
      end
   end

   task automatic pin(input string name, input logic [23:0] got, input logic [23:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s actual=%h required=%h", name, got, want);
      end
   endtask

   task automatic xact(input string name, input logic [95:0] n, input logic [95:0] l,
                       input logic [23:0] c, input logic [23:0] bg, input logic [31:0] amb,
                       input logic h, input logic [23:0] want, input int want_lat);
      int lat;
      @(negedge clock);
      normal = n; light_dir = l; base_color = c; bg_color = bg; ambient = amb; hit = h;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      normal = ~n; base_color = ~c; bg_color = ~bg; hit = ~h;
      lat = 1;
      while (!ready && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      nvec++;
      if (!ready || lat != want_lat) begin
         nerr++;
         $display("FAIL %s_latency actual=%0d required=%0d", name, lat, want_lat);
      end
      pin({name, "_pixel"}, pixel, want);
      @(negedge clock);
   endtask

   function automatic logic [31:0] rcomp();
      return 32'($urandom_range(32'h30000)) - 32'h18000;
   endfunction

   localparam logic [31:0] P1 = 32'h0001_0000;
   localparam logic [23:0] BASE = 24'hC8_64_32;

   initial begin
      int rcount;
      reset = 1'b0; start = 1'b0; hit = 1'b0;
      normal = '0; light_dir = '0; base_color = '0; bg_color = '0; ambient = '0;

      pin("model_unit",  model_px({32'h0, 32'h0, P1}, {32'h0, 32'h0, P1}, BASE, 32'h0), BASE);
      pin("model_half",  model_px({32'h0, 32'h0, 32'h8000}, {32'h0, 32'h0, P1}, BASE, 32'h0), 24'h64_32_19);
      pin("model_back",  model_px({32'h0, 32'h0, 32'hFFFF_0000}, {32'h0, 32'h0, P1}, BASE, 32'h0), 24'h0);
      pin("model_over",  model_px({32'h0, 32'h0, 32'h2_0000}, {32'h0, 32'h0, P1}, BASE, 32'h0), BASE);
`ifdef SHADE_AMBIENT_EN
      pin("model_amb",   model_px({32'h0, 32'h0, 32'h8000}, {32'h0, 32'h0, P1}, BASE, 32'h4000), 24'h96_4B_25);
`else
      pin("model_noamb", model_px({32'h0, 32'h0, 32'h8000}, {32'h0, 32'h0, P1}, BASE, 32'h4000), 24'h64_32_19);
`endif

      repeat (3) @(negedge clock);
      reset = 1'b1;

      xact("unit", {32'h0, 32'h0, P1}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h0, 1'b1, BASE, 8);
      xact("half", {32'h0, 32'h0, 32'h8000}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h0, 1'b1, 24'h64_32_19, 8);
      xact("back", {32'h0, 32'h0, 32'hFFFF_0000}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h0, 1'b1, 24'h0, 8);
      xact("over", {32'h0, 32'h0, 32'h2_0000}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h0, 1'b1, BASE, 8);
      xact("miss", {32'h0, 32'h0, P1}, {32'h0, 32'h0, P1}, BASE, 24'h0A_14_1E, 32'h0, 1'b0, 24'h0A_14_1E, 1);
`ifdef SHADE_AMBIENT_EN
      xact("amb_half", {32'h0, 32'h0, 32'h8000}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h4000, 1'b1, 24'h96_4B_25, 8);
      xact("amb_unit", {32'h0, 32'h0, P1}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h4000, 1'b1, BASE, 8);
`else
      xact("amb_ign", {32'h0, 32'h0, 32'h8000}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h4000, 1'b1, 24'h64_32_19, 8);
`endif

      // Start pulses while busy must not produce extra results
      @(negedge clock);
      normal = {32'h0, 32'h0, P1}; light_dir = {32'h0, 32'h0, P1}; base_color = BASE; hit = 1'b1;
      start = 1'b1;
      @(negedge clock);
      rcount = 0;
      for (int i = 0; i < 14; i++) begin
         start = (i >= 1 && i <= 5);
         if (ready) rcount++;
         @(negedge clock);
      end
      start = 1'b0;
      nvec++;
      if (rcount != 1) begin
         nerr++;
         $display("FAIL busy_start ready_pulses actual=%0d required=1", rcount);
      end

      // Reset while in the third dot-product step
      @(negedge clock);
      normal = {32'h0, 32'h0, P1}; light_dir = {32'h0, 32'h0, P1}; base_color = 24'h11_22_33; hit = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      pin("rst_pixel", pixel, 24'h0);
      nvec++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL rst_ctrl actual=%b%b required=00", ready, busy);
      end
      reset = 1'b1;
      xact("after_rst", {32'h0, 32'h0, P1}, {32'h0, 32'h0, P1}, BASE, 24'h0, 32'h0, 1'b1, BASE, 8);

      // Randomized traffic; the model and per-cycle compare do the checking
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         reset      = ($urandom_range(299) != 0);
         start      = ($urandom_range(2) == 0);
         hit        = ($urandom_range(3) != 0);
         normal     = {rcomp(), rcomp(), rcomp()};
         light_dir  = {rcomp(), rcomp(), rcomp()};
         base_color = 24'($urandom);
         bg_color   = 24'($urandom);
         ambient    = 32'($urandom_range(32'h10000)) - 32'h8000;
      end
      @(negedge clock);
      start = 1'b0;
      reset = 1'b1;
      repeat (12) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
